// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    localparam int          DIGIT_W    = 4;
    localparam int          NUM_DIGITS = 4;
    localparam logic [3:0]  BCD_MAX    = 4'd9;

    // Saturate a loaded digit at its legal maximum.
    function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] max_val);
        return (d > max_val) ? max_val : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One decade down-counter; wraps to MAX on borrow, load has priority over count.
module bcd_down_digit
    import timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = BCD_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] ld_val,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    // Next digit value: load, decrement with wrap, or hold.
    always_comb begin
        q_d = q_q;
        if (ld) begin
            q_d = ld_val;
        end else if (en) begin
            q_d = (q_q == '0) ? MAX : q_q - 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign borrow = en && (q_q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: FSM, load clamping, zero detect and done pulse.
//
//   state      | meaning
//   -----------+----------------------------------------------
//   ST_IDLE    | loaded/reset, waiting for start
//   ST_RUN     | decrementing one second per tick
//   ST_PAUSED  | countdown suspended, digits held
//   ST_EXPIRED | reached 00:00, held until load or reset
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned SEC_TENS_MAX = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] digits,
    output logic        running,
    output logic        done,
    output logic        expired
);

    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX_L = DIGIT_W'(SEC_TENS_MAX);

    state_e      state_q, state_d;
    logic        done_q, done_d;
    logic [15:0] load_clamped;
    logic        dec;
    logic        is_zero;
    logic        is_one;
    logic [2:0]  borrow;
    logic        min_tens_borrow_unused;

    // Clamp each loaded nibble to the largest value its position can hold.
    always_comb begin
        load_clamped = {bcd_clamp(load_val[15:12], BCD_MAX),
                        bcd_clamp(load_val[11:8],  BCD_MAX),
                        bcd_clamp(load_val[7:4],   SEC_TENS_MAX_L),
                        bcd_clamp(load_val[3:0],   BCD_MAX)};
    end

    // A tick only counts in RUN when neither load nor pause overrides it.
    assign dec     = (state_q == ST_RUN) && tick && !load && !pause;
    assign is_zero = (digits == 16'h0000);
    assign is_one  = (digits == 16'h0001);

    bcd_down_digit #(.MAX(BCD_MAX)) u_sec_ones (
        .clk(clk), .reset(reset), .en(dec), .ld(load),
        .ld_val(load_clamped[3:0]), .q(digits[3:0]), .borrow(borrow[0])
    );

    bcd_down_digit #(.MAX(SEC_TENS_MAX_L)) u_sec_tens (
        .clk(clk), .reset(reset), .en(borrow[0]), .ld(load),
        .ld_val(load_clamped[7:4]), .q(digits[7:4]), .borrow(borrow[1])
    );

    bcd_down_digit #(.MAX(BCD_MAX)) u_min_ones (
        .clk(clk), .reset(reset), .en(borrow[1]), .ld(load),
        .ld_val(load_clamped[11:8]), .q(digits[11:8]), .borrow(borrow[2])
    );

    // Minute tens never wraps: RUN is left at 00:00, so its borrow cannot fire.
    bcd_down_digit #(.MAX(BCD_MAX)) u_min_tens (
        .clk(clk), .reset(reset), .en(borrow[2]), .ld(load),
        .ld_val(load_clamped[15:12]), .q(digits[15:12]), .borrow(min_tens_borrow_unused)
    );

    // Next-state and done pulse, priority load > pause > start > tick.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (is_zero) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick && is_one) begin
                        state_d = ST_EXPIRED;
                        done_d  = 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (start && !pause) begin
                        if (is_zero) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and done registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign running = (state_q == ST_RUN);
    assign expired = (state_q == ST_EXPIRED);
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus random stimulus
// against a seconds-based reference model.
module tb_bcd_countdown_timer;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic        clk, reset, tick, load, start, pause;
    logic [15:0] load_val;
    logic [15:0] digits;
    logic        running, done, expired;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_st;
    logic [15:0] m_dig;
    logic        m_done;

    bcd_countdown_timer #(.SEC_TENS_MAX(5)) dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .digits(digits), .running(running),
        .done(done), .expired(expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int to_sec(input logic [15:0] d);
        return (int'(d[15:12]) * 10 + int'(d[11:8])) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m, ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [3:0] sat(input logic [3:0] v, input int mx);
        return (int'(v) > mx) ? 4'(mx) : v;
    endfunction

    task automatic model_step(input logic ld, input logic [15:0] lv, input logic st,
                              input logic ps, input logic tk);
        int s;
        m_done = 1'b0;
        if (ld) begin
            m_st  = M_IDLE;
            m_dig = {sat(lv[15:12], 9), sat(lv[11:8], 9), sat(lv[7:4], 5), sat(lv[3:0], 9)};
        end else if (m_st == M_IDLE || (m_st == M_PAUSED && !ps)) begin
            if (st) begin
                if (m_dig == 16'h0000) begin
                    m_st   = M_EXP;
                    m_done = 1'b1;
                end else begin
                    m_st = M_RUN;
                end
            end
        end else if (m_st == M_RUN) begin
            if (ps) begin
                m_st = M_PAUSED;
            end else if (tk) begin
                s     = to_sec(m_dig) - 1;
                m_dig = to_bcd(s);
                if (s == 0) begin
                    m_st   = M_EXP;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic ld, input logic [15:0] lv,
                        input logic st, input logic ps, input logic tk);
        load = ld; load_val = lv; start = st; pause = ps; tick = tk;
        model_step(ld, lv, st, ps, tk);
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
        chk({tag, "_dig"}, digits, m_dig);
        chk({tag, "_flg"}, {13'd0, running, expired, done},
            {13'd0, m_st == M_RUN, m_st == M_EXP, m_done});
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic        r_ld, r_st, r_ps, r_tk;
        logic [15:0] r_lv;
        int          r;

        reset = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = 16'h0;
        m_st = M_IDLE; m_dig = 16'h0; m_done = 1'b0;
        #3;
        chk("rst_dig", digits, 16'h0000);
        chk("rst_flg", {13'd0, running, expired, done}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step("idle_hold", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // 01:30 down to expiry
        step("a_load", 1'b1, 16'h0130, 1'b0, 1'b0, 1'b0);
        step("a_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        ticks("a_t1", 1);
        chk("a_0129", digits, 16'h0129);
        ticks("a_t30", 30);
        chk("a_0059", digits, 16'h0059);
        ticks("a_t59", 59);
        chk("a_0000", digits, 16'h0000);
        chk("a_done", {15'd0, done}, 16'h0001);
        step("a_after", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("a_done_low", {14'd0, done, expired}, 16'h0001);

        // Full borrow chain
        step("b_load", 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        step("b_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        ticks("b_t1", 1);
        chk("b_0959", digits, 16'h0959);

        // Pause / resume
        step("c_load", 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        step("c_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        ticks("c_t2", 2);
        step("c_pause", 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        ticks("c_tp", 3);
        chk("c_held", {digits[15:1], running}, {15'h0001, 1'b0});
        step("c_sp_paused", 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        step("c_resume", 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        step("c_sp_run", 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        step("c_resume2", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        ticks("c_t3", 3);
        chk("c_done", {digits[14:0], done}, 16'h0001);

        // Clamp, then load+start+tick priority
        step("d_clamp", 1'b1, 16'h0A7C, 1'b0, 1'b0, 1'b0);
        chk("d_0959", digits, 16'h0959);
        step("d_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        step("d_prio", 1'b1, 16'h0130, 1'b1, 1'b0, 1'b1);
        chk("d_nodec", {digits[14:0], running}, {15'h0130 >> 0 & 15'h7FFF, 1'b0});

        // Asynchronous reset mid-run
        step("e_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        ticks("e_t2", 2);
        reset = 1'b1;
        #2;
        chk("e_rst_dig", digits, 16'h0000);
        chk("e_rst_flg", {13'd0, running, expired, done}, 16'h0000);
        m_st = M_IDLE; m_dig = 16'h0; m_done = 1'b0;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        step("e_zstart", 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("e_exp", {14'd0, expired, done}, 16'h0003);
        step("e_after", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Expired is sticky until load
        step("f_start", 1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        step("f_pause", 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        ticks("f_t", 2);
        step("f_load", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        chk("f_idle", {digits[14:0], expired}, {15'h0002, 1'b0});

        // Random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            r    = int'($urandom_range(0, 99));
            r_ld = (r < 3);
            r_lv = ($urandom_range(0, 1) == 1) ? 16'($urandom())
                 : {8'h00, 4'($urandom_range(0, 6)), 4'($urandom_range(0, 11))};
            r_st = (r >= 3 && r < 13) && (m_st != M_RUN);
            r_ps = (r >= 13 && r < 18);
            r_tk = ($urandom_range(0, 1) == 1);
            step("rnd", r_ld, r_lv, r_st, r_ps, r_tk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
